// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: drives sequential instruction memory and queues PC-tagged words for decode.
module instr_fetch_buffer #(
  parameter int DEPTH = 4,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   next_op,
  input  logic [31:0]            instr_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  logic            pending_q, pending_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q [DEPTH];
  logic            push, pop;
  // Credit counts the in-flight word so the FIFO can never overflow; a same-cycle pop is ignored.
  always_comb begin
    next_op      = !reset && !flush && (({1'b0, count_q} + (AW+2)'(pending_q)) < DEPTH_W);
    out_valid    = !reset && (count_q != '0);
    out_instr    = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    out_pc       = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    push         = pending_q && !flush;
    pop          = out_valid && out_ready && !flush;
    pending_d    = next_op;
    pending_pc_d = next_op ? fetch_pc_q : pending_pc_q;
    fetch_pc_d   = next_op ? fetch_pc_q + 32'd4 : fetch_pc_q;
    wr_ptr_d     = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d      = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  assign count = count_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      fetch_pc_q   <= PC_RESET;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      fetch_pc_q   <= fetch_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      instr_mem_q[wr_ptr_q] <= instr_in;
      pc_mem_q[wr_ptr_q]    <= pending_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: memory model plus in-order PC scoreboard for instr_fetch_buffer.
module tb_instr_fetch_buffer;
  localparam int DEPTH = 4;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr_in = '0;
  logic        next_op, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  count;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_deliv = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] exp_pc = '0;
  bit          mon_en = 1'b0;

  instr_fetch_buffer #(.DEPTH(DEPTH), .PC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset), .next_op(next_op), .instr_in(instr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] i;
    i = (a >> 2) % 3;
    return i == 0 ? 32'h00A00093 : i == 1 ? 32'h00108133 : 32'h00208203;
  endfunction

  // Sequential memory: address advances on every sampled request, word visible the next cycle.
  always @(posedge clock) begin
    if (reset) mem_addr <= '0;
    else if (next_op) begin
      instr_in <= word(mem_addr);
      mem_addr <= mem_addr + 32'd4;
    end
  end

  // Scoreboard: every accepted word must carry the next expected PC and that PC's memory word.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      n_tests++;
      if (count > 3'(DEPTH) || out_valid !== (count != 3'd0)) begin
        n_fail++;
        $display("FAIL occupancy: count=%0d out_valid=%b required count<=%0d and out_valid==(count!=0)", count, out_valid, DEPTH);
      end
      if (!flush && out_valid && out_ready) begin
        n_tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          n_fail++;
          $display("FAIL stream: pc=%h instr=%h required pc=%h instr=%h", out_pc, out_instr, exp_pc, word(exp_pc));
        end
        exp_pc  += 32'd4;
        n_deliv++;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    tick;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = rdy;
    tick;
    tick;
    reset = 1'b0;
    exp_pc = 32'h0;
    n_deliv = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    out_ready = 1'b1;
    mon_en = 1'b1;
    tick;
    tick;
    @(negedge clock);
    n_tests++;
    if (next_op !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: next_op=%b valid=%b pc=%h instr=%h required all 0", next_op, out_valid, out_pc, out_instr);
    end
    tick;
    reset = 1'b0;
    exp_pc = 32'h0;
    n_deliv = 0;
    @(negedge clock);
    n_tests++;
    if (next_op !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL first_request: next_op=%b valid=%b count=%0d required 1 0 0", next_op, out_valid, count);
    end
    tick;
    @(negedge clock);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: valid=%b required 0", out_valid);
    end
    tick;
    @(negedge clock);
    n_tests++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00A00093) begin
      n_fail++;
      $display("FAIL latency_n2: valid=%b pc=%h instr=%h required 1 00000000 00a00093", out_valid, out_pc, out_instr);
    end
    repeat (8) tick;
    n_tests++;
    if (n_deliv != 8 || exp_pc !== 32'h20) begin
      n_fail++;
      $display("FAIL throughput: delivered=%0d next_pc=%h required 8 00000020", n_deliv, exp_pc);
    end
  endtask

  task automatic test_backpressure;
    int pulses;
    bit ok;
    do_reset(1'b0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (next_op) pulses++;
      tick;
    end
    @(negedge clock);
    n_tests++;
    if (pulses != DEPTH || count !== 3'(DEPTH) || next_op !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_fill: pulses=%0d count=%0d next_op=%b required %0d %0d 0", pulses, count, next_op, DEPTH, DEPTH);
    end
    tick;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (n_deliv >= 6) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL backpressure_resume: delivered=%0d required >=6 within 20 cycles", n_deliv);
    end
  endtask

  task automatic test_toggle;
    do_reset(1'b0);
    for (int i = 0; i < 2000 && n_deliv < 64; i++) begin
      out_ready = ~out_ready;
      tick;
    end
    out_ready = 1'b0;
    n_tests++;
    if (n_deliv != 64 || exp_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL toggle_stream: delivered=%0d next_pc=%h required 64 00000100", n_deliv, exp_pc);
    end
  endtask

  task automatic test_flush;
    bit ok;
    do_reset(1'b0);
    repeat (4) tick;
    flush = 1'b1;
    @(negedge clock);
    n_tests++;
    if (count !== 3'd3 || next_op !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_setup: count=%0d next_op=%b required 3 0", count, next_op);
    end
    tick;
    flush = 1'b0;
    exp_pc = mem_addr;
    n_tests++;
    if (mem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL flush_fetch_pc: next fetch=%h required 00000010", mem_addr);
    end
    @(negedge clock);
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || next_op !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: count=%0d valid=%b next_op=%b required 0 0 1", count, out_valid, next_op);
    end
    tick;
    @(negedge clock);
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_drop: count=%0d required 0", count);
    end
    tick;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok || out_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL flush_resume: seen=%b pc=%h required 1 00000010", ok, out_pc);
    end
  endtask

  task automatic test_flush_pop;
    do_reset(1'b1);
    repeat (6) tick;
    flush = 1'b1;
    @(negedge clock);
    n_tests++;
    if (count !== 3'd1 || out_valid !== 1'b1 || next_op !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pop_setup: count=%0d valid=%b next_op=%b required 1 1 0", count, out_valid, next_op);
    end
    tick;
    flush = 1'b0;
    exp_pc = mem_addr;
    @(negedge clock);
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_pop: count=%0d valid=%b required 0 0", count, out_valid);
    end
    repeat (6) tick;
    n_tests++;
    if (n_deliv < 8) begin
      n_fail++;
      $display("FAIL flush_pop_resume: delivered=%0d required >=8", n_deliv);
    end
  endtask

  task automatic test_random;
    bit f;
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      f = flush;
      tick;
      if (f) begin
        exp_pc = mem_addr;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL random_flush: count=%0d valid=%b required 0 0", count, out_valid);
        end
      end
    end
    flush = 1'b0;
    n_tests++;
    if (n_deliv < 50) begin
      n_fail++;
      $display("FAIL random_progress: delivered=%0d required >=50", n_deliv);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset(1'b1);
    repeat (6) tick;
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (next_op !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_during: next_op=%b valid=%b pc=%h instr=%h required all 0", next_op, out_valid, out_pc, out_instr);
    end
    tick;
    reset = 1'b0;
    exp_pc = 32'h0;
    n_deliv = 0;
    @(negedge clock);
    n_tests++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_after: count=%0d valid=%b pc=%h required 0 0 0", count, out_valid, out_pc);
    end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok || out_pc !== 32'h0 || out_instr !== 32'h00A00093) begin
      n_fail++;
      $display("FAIL reset_mid_first: seen=%b pc=%h instr=%h required 1 00000000 00a00093", ok, out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset;
    test_backpressure;
    test_toggle;
    test_flush;
    test_flush_pop;
    test_random;
    test_reset_mid;
    tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
